cb_arb: RTL and testbench
=========================

CB_ARB -- requirements
Module: cb_arb

Interface
REQ-001 Parameter: none; widths come from the shared header macro `PORT (default 3, i.e. 4 ports, index 0..`PORT).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_  input  1  synchronous, active-low reset.
REQ-004 req0..req3  input  [`PORT:0]  one-hot destination request of input i (bit j = wants output j); zero = no request.
REQ-005 vld0..vld3  input  1  input i is presenting a flit this cycle.
REQ-006 last0..last3  input  1  qualifies vld i: flit is the packet tail.
REQ-007 d0..d3  output  [`PORT:0]  crossbar select for output j; bit i set = input i drives output j; at most one bit set.
REQ-008 gnt0..gnt3  output  1  input i currently owns some output (OR of bit i over d0..d3).

Function
REQ-009 One independent arbiter per output j, each with a 2-state FSM: IDLE, BUSY.
REQ-010 IDLE: candidates = inputs i with req_i[j]=1; if any, select by round-robin starting at pointer ptr_j, register grantee, go BUSY.
REQ-011 Grant latency: d_j is set in the cycle after the request is first seen in IDLE (registered outputs, no combinational path from req to d).
REQ-012 On grant, ptr_j SHALL become (grantee+1) mod 4; ptr_j is unchanged when no grant is made.
REQ-013 BUSY: d_j holds the grantee one-hot until release; no other input can preempt.
REQ-014 Release when the grantee has vld_i & last_i = 1, or drops req_i[j]; d_j becomes 0 the next cycle and the FSM returns to IDLE.
REQ-015 After release, output j stays idle for exactly one cycle before a new grant (one-cycle bubble, no back-to-back grant in the release cycle).
REQ-016 Multi-hot req_i SHALL be masked to its lowest set bit before arbitration, so one input never holds two outputs.
REQ-017 Each input's gnt_i is registered and equals OR of d_j[i] for all j.
REQ-018 Simultaneous requests from several inputs to different outputs are granted in the same cycle; there is no cross-output dependence.
REQ-019 A tail flit arriving in the grant cycle itself (single-flit packet) releases normally: d_j is set for exactly one cycle.
REQ-020 A request to output j while j is BUSY waits; it is not lost and is not queued beyond the level of req_i.

Reset
REQ-021 While rst_=0 at a clock edge: all FSMs go to IDLE, d0..d3=0, gnt0..gnt3=0, ptr_j=j.
REQ-022 Reset mid-packet SHALL drop all grants the following cycle; no release handshake is required.
REQ-023 The first grant after reset is possible in the cycle after rst_ returns high plus the grant latency.

Structure
REQ-024 FSM state encodings and the port-count/pointer width SHALL live in the shared header alongside `PORT and `PKTW.
REQ-025 One sub-module, cb_rrarb, per output: 4-way round-robin arbiter with FSM, pointer and release logic; cb_arb instantiates 4 copies and the request mask/transposition.
REQ-026 cb_arb's d0..d3 connect directly to the crossbar's select inputs.

Verification
REQ-027 Reset, then req0=4'b0010 with a 3-flit packet (last on flit 3) -> d1=4'b0001 one cycle later, held until the cycle after last0, then d1=0 and gnt0=0.
REQ-028 req0..req3 all =4'b0001 after reset (ptr_0=0), single-flit packets -> d0 grants input 0,1,2,3 in order with a one-cycle gap between grants.
REQ-029 req0=4'b0001, req1=4'b0010, req2=4'b0100, req3=4'b1000 simultaneously -> d0..d3 = 0001,0010,0100,1000 in the same cycle; gnt0..3 all 1.
REQ-030 req2=4'b0110 (multi-hot) -> only d1[2] set; d2 stays 0.
REQ-031 rst_ pulsed low while d3=4'b0100 is mid-packet -> d3=0 and gnt2=0 the next cycle; ptr_3=3.
REQ-032 Grantee drops req before tail -> release the next cycle; waiting requester granted after the one-cycle bubble.

Source files
------------

// File: rtl/cb_arb_pkg.sv
// Shared header for the crossbar arbiter: port count, pointer width and FSM encoding.
// PORT is the highest port index (ports 0..PORT); PKTW is the packet-length width.
`ifndef PORT
`define PORT 3
`endif
`ifndef PKTW
`define PKTW 8
`endif

package cb_arb_pkg;
   localparam int NPORT = `PORT + 1;
   localparam int PTRW  = (NPORT > 1) ? $clog2(NPORT) : 1;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   // Keep only the lowest set bit so an input can never claim two outputs.
   function automatic logic [NPORT-1:0] lowest_bit(input logic [NPORT-1:0] v);
      return v & (~v + NPORT'(1));
   endfunction
endpackage

// File: rtl/cb_rrarb.sv
// Round-robin arbiter for one crossbar output: holds a grant until tail flit
// or request drop, then idles one cycle before re-arbitrating.
//
// state    | meaning
// ARB_IDLE | no owner; grant the first requester at or after ptr_q
// ARB_BUSY | sel_q holds the owner one-hot until tail or request drop

module cb_rrarb
   import cb_arb_pkg::*;
#(
   parameter int RST_PTR = 0
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic [NPORT-1:0] req_i,
   input  logic [NPORT-1:0] vld_i,
   input  logic [NPORT-1:0] last_i,
   output logic [NPORT-1:0] sel_o
);

   arb_state_e       state_q;
   logic [NPORT-1:0] sel_q;
   logic [PTRW-1:0]  ptr_q;
   logic [PTRW-1:0]  pick;
   logic             pick_vld;
   logic             rel;

   // Scan from the highest offset down so the nearest requester to ptr_q wins.
   always_comb begin
      pick     = ptr_q;
      pick_vld = 1'b0;
      for (int k = NPORT - 1; k >= 0; k--) begin
         if (req_i[(int'(ptr_q) + k) % NPORT]) begin
            pick     = PTRW'((int'(ptr_q) + k) % NPORT);
            pick_vld = 1'b1;
         end
      end
   end

   assign rel = (|(sel_q & ~req_i)) | (|(sel_q & vld_i & last_i));

   always_ff @(posedge clk) begin
      if (!rst_) begin
         state_q <= ARB_IDLE;
         sel_q   <= '0;
         ptr_q   <= PTRW'(RST_PTR);
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (pick_vld) begin
                  sel_q   <= NPORT'(1) << pick;
                  ptr_q   <= PTRW'((int'(pick) + 1) % NPORT);
                  state_q <= ARB_BUSY;
               end
            end
            ARB_BUSY: begin
               if (rel) begin
                  sel_q   <= '0;
                  state_q <= ARB_IDLE;
               end
            end
         endcase
      end
   end

   assign sel_o = sel_q;

endmodule

// File: rtl/cb_arb.sv
// 4x4 crossbar arbiter: masks each input's request to one destination,
// transposes requests per output and runs one round-robin arbiter per output.

module cb_arb
   import cb_arb_pkg::*;
(
   input  logic             clk,
   input  logic             rst_,
   input  logic [NPORT-1:0] req0,
   input  logic [NPORT-1:0] req1,
   input  logic [NPORT-1:0] req2,
   input  logic [NPORT-1:0] req3,
   input  logic             vld0,
   input  logic             vld1,
   input  logic             vld2,
   input  logic             vld3,
   input  logic             last0,
   input  logic             last1,
   input  logic             last2,
   input  logic             last3,
   output logic [NPORT-1:0] d0,
   output logic [NPORT-1:0] d1,
   output logic [NPORT-1:0] d2,
   output logic [NPORT-1:0] d3,
   output logic             gnt0,
   output logic             gnt1,
   output logic             gnt2,
   output logic             gnt3
);

   logic [NPORT-1:0] req_m [NPORT];
   logic [NPORT-1:0] col   [NPORT];
   logic [NPORT-1:0] sel   [NPORT];
   logic [NPORT-1:0] vld_v;
   logic [NPORT-1:0] last_v;
   logic [NPORT-1:0] gnt_v;

   assign req_m[0] = lowest_bit(req0);
   assign req_m[1] = lowest_bit(req1);
   assign req_m[2] = lowest_bit(req2);
   assign req_m[3] = lowest_bit(req3);
   assign vld_v    = {vld3, vld2, vld1, vld0};
   assign last_v   = {last3, last2, last1, last0};

   // col[j][i]: input i wants output j.
   always_comb begin
      for (int j = 0; j < NPORT; j++) begin
         col[j] = '0;
         for (int i = 0; i < NPORT; i++) col[j][i] = req_m[i][j];
      end
   end

   for (genvar j = 0; j < NPORT; j++) begin : g_out
      cb_rrarb #(.RST_PTR(j)) u_rrarb (
         .clk    (clk),
         .rst_   (rst_),
         .req_i  (col[j]),
         .vld_i  (vld_v),
         .last_i (last_v),
         .sel_o  (sel[j])
      );
   end

   // Grants are an OR of registered selects, so they track d0..d3 exactly.
   always_comb begin
      gnt_v = '0;
      for (int j = 0; j < NPORT; j++) gnt_v = gnt_v | sel[j];
   end

   assign d0   = sel[0];
   assign d1   = sel[1];
   assign d2   = sel[2];
   assign d3   = sel[3];
   assign gnt0 = gnt_v[0];
   assign gnt1 = gnt_v[1];
   assign gnt2 = gnt_v[2];
   assign gnt3 = gnt_v[3];

endmodule

// File: tb/tb_cb_arb.sv
// Bench for cb_arb: directed scenarios plus randomized traffic checked
// against a per-output owner/pointer model.

module tb_cb_arb;

   logic       clk = 1'b0;
   logic       rst_ = 1'b0;
   logic [3:0] rq [4];
   logic [3:0] vl, lt;
   logic [3:0] d0, d1, d2, d3;
   logic       gnt0, gnt1, gnt2, gnt3;
   logic [3:0] dv [4];
   logic [3:0] gv;

   int nvec = 0;
   int nerr = 0;

   int m_busy [4];
   int m_own  [4];
   int m_ptr  [4];

   always #5 clk = ~clk;

   cb_arb dut (
      .clk(clk), .rst_(rst_),
      .req0(rq[0]), .req1(rq[1]), .req2(rq[2]), .req3(rq[3]),
      .vld0(vl[0]), .vld1(vl[1]), .vld2(vl[2]), .vld3(vl[3]),
      .last0(lt[0]), .last1(lt[1]), .last2(lt[2]), .last3(lt[3]),
      .d0(d0), .d1(d1), .d2(d2), .d3(d3),
      .gnt0(gnt0), .gnt1(gnt1), .gnt2(gnt2), .gnt3(gnt3)
   );

   assign dv[0] = d0;
   assign dv[1] = d1;
   assign dv[2] = d2;
   assign dv[3] = d3;
   assign gv    = {gnt3, gnt2, gnt1, gnt0};

   // Model: each output has an owner (or none) and a next-start pointer.
   task automatic model_step();
      int dest [4];
      int c;
      for (int i = 0; i < 4; i++) begin
         dest[i] = -1;
         for (int b = 3; b >= 0; b--) if (rq[i][b]) dest[i] = b;
      end
      if (!rst_) begin
         for (int j = 0; j < 4; j++) begin
            m_busy[j] = 0; m_own[j] = 0; m_ptr[j] = j;
         end
      end else begin
         for (int j = 0; j < 4; j++) begin
            if (m_busy[j] != 0) begin
               if (dest[m_own[j]] != j || (vl[m_own[j]] && lt[m_own[j]])) m_busy[j] = 0;
            end else begin
               for (int k = 0; k < 4; k++) begin
                  c = (m_ptr[j] + k) % 4;
                  if (m_busy[j] == 0 && dest[c] == j) begin
                     m_busy[j] = 1; m_own[j] = c; m_ptr[j] = (c + 1) % 4;
                  end
               end
            end
         end
      end
   endtask

   function automatic logic [3:0] model_d(input int j);
      logic [3:0] r;
      r = '0;
      if (m_busy[j] != 0) r[m_own[j]] = 1'b1;
      return r;
   endfunction

   function automatic logic [3:0] model_gnt();
      logic [3:0] r;
      r = '0;
      for (int j = 0; j < 4; j++) if (m_busy[j] != 0) r[m_own[j]] = 1'b1;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic clear_inputs();
      for (int i = 0; i < 4; i++) rq[i] = '0;
      vl = '0;
      lt = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_ = 1'b0;
      tick();
      tick();
      rst_ = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_ = 1'b0;
      rq[0] = 4'b0001;
      tick();
      tick();
      nvec++;
      if ({d3, d2, d1, d0} !== 16'h0) begin
         nerr++; $display("FAIL reset_d: got %h want 0000", {d3, d2, d1, d0});
      end
      nvec++;
      if (gv !== 4'b0000) begin
         nerr++; $display("FAIL reset_gnt: got %b want 0000", gv);
      end
      rst_ = 1'b1;
      tick();
      nvec++;
      if (d0 !== 4'b0001) begin
         nerr++; $display("FAIL first_grant: d0 got %b want 0001", d0);
      end
      clear_inputs();
      tick();
      tick();
   endtask

   task automatic test_single_packet();
      do_reset();
      rq[0] = 4'b0010;
      tick();
      nvec++;
      if (d1 !== 4'b0001 || gnt0 !== 1'b1) begin
         nerr++; $display("FAIL pkt_grant: d1 %b gnt0 %b want 0001 1", d1, gnt0);
      end
      vl[0] = 1'b1;
      for (int f = 1; f <= 2; f++) begin
         tick();
         nvec++;
         if (d1 !== 4'b0001) begin
            nerr++; $display("FAIL pkt_hold%0d: d1 got %b want 0001", f, d1);
         end
      end
      lt[0] = 1'b1;
      tick();
      nvec++;
      if (d1 !== 4'b0000 || gnt0 !== 1'b0) begin
         nerr++; $display("FAIL pkt_release: d1 %b gnt0 %b want 0000 0", d1, gnt0);
      end
      clear_inputs();
      tick();
   endtask

   task automatic test_rr_order();
      logic [3:0] exp [7];
      exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000};
      do_reset();
      for (int i = 0; i < 4; i++) rq[i] = 4'b0001;
      vl = 4'b1111;
      lt = 4'b1111;
      for (int c = 0; c < 7; c++) begin
         tick();
         nvec++;
         if (d0 !== exp[c]) begin
            nerr++; $display("FAIL rr_order c%0d: d0 got %b want %b", c, d0, exp[c]);
         end
      end
      clear_inputs();
      tick();
   endtask

   task automatic test_parallel();
      do_reset();
      for (int i = 0; i < 4; i++) rq[i] = 4'b0001 << i;
      tick();
      for (int j = 0; j < 4; j++) begin
         nvec++;
         if (dv[j] !== (4'b0001 << j)) begin
            nerr++; $display("FAIL parallel d%0d: got %b want %b", j, dv[j], 4'b0001 << j);
         end
      end
      nvec++;
      if (gv !== 4'b1111) begin
         nerr++; $display("FAIL parallel_gnt: got %b want 1111", gv);
      end
      clear_inputs();
      tick();
      nvec++;
      if ({d3, d2, d1, d0} !== 16'h0) begin
         nerr++; $display("FAIL parallel_drop: got %h want 0000", {d3, d2, d1, d0});
      end
   endtask

   task automatic test_multihot();
      do_reset();
      rq[2] = 4'b0110;
      tick();
      nvec++;
      if (d1 !== 4'b0100 || d2 !== 4'b0000) begin
         nerr++; $display("FAIL multihot: d1 %b d2 %b want 0100 0000", d1, d2);
      end
      clear_inputs();
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      rq[2] = 4'b1000;
      tick();
      nvec++;
      if (d3 !== 4'b0100) begin
         nerr++; $display("FAIL mid_grant: d3 got %b want 0100", d3);
      end
      vl[2] = 1'b1;
      tick();
      rst_ = 1'b0;
      tick();
      nvec++;
      if (d3 !== 4'b0000 || gnt2 !== 1'b0) begin
         nerr++; $display("FAIL mid_reset: d3 %b gnt2 %b want 0000 0", d3, gnt2);
      end
      rst_ = 1'b1;
      vl = '0;
      rq[2] = 4'b0000;
      rq[1] = 4'b1000;
      rq[3] = 4'b1000;
      tick();
      nvec++;
      if (d3 !== 4'b1000) begin
         nerr++; $display("FAIL ptr3_after_reset: d3 got %b want 1000", d3);
      end
      clear_inputs();
      tick();
   endtask

   task automatic test_drop_req();
      do_reset();
      rq[0] = 4'b0001;
      rq[1] = 4'b0001;
      tick();
      nvec++;
      if (d0 !== 4'b0001) begin
         nerr++; $display("FAIL drop_grant: d0 got %b want 0001", d0);
      end
      vl[0] = 1'b1;
      tick();
      rq[0] = 4'b0000;
      vl[0] = 1'b0;
      tick();
      nvec++;
      if (d0 !== 4'b0000) begin
         nerr++; $display("FAIL drop_release: d0 got %b want 0000", d0);
      end
      tick();
      nvec++;
      if (d0 !== 4'b0010) begin
         nerr++; $display("FAIL drop_next: d0 got %b want 0010", d0);
      end
      clear_inputs();
      tick();
   endtask

   task automatic test_random();
      int r;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 4; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4)      rq[i] = 4'b0000;
            else if (r < 9) rq[i] = 4'b0001 << $urandom_range(0, 3);
            else            rq[i] = 4'($urandom_range(0, 15));
            vl[i] = 1'($urandom_range(0, 1));
            lt[i] = ($urandom_range(0, 3) == 0);
         end
         rst_ = ($urandom_range(0, 39) != 0);
         tick();
         for (int j = 0; j < 4; j++) begin
            nvec++;
            if (dv[j] !== model_d(j)) begin
               nerr++; $display("FAIL rand c%0d d%0d: got %b want %b", c, j, dv[j], model_d(j));
            end
         end
         nvec++;
         if (gv !== model_gnt()) begin
            nerr++; $display("FAIL rand c%0d gnt: got %b want %b", c, gv, model_gnt());
         end
      end
      rst_ = 1'b1;
      clear_inputs();
      tick();
   endtask

   initial begin
      for (int j = 0; j < 4; j++) begin
         m_busy[j] = 0; m_own[j] = 0; m_ptr[j] = j;
      end
      clear_inputs();
      test_reset();
      test_single_packet();
      test_rr_order();
      test_parallel();
      test_multihot();
      test_reset_mid();
      test_drop_req();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
